discriminant_sqrt_feeder: RTL and testbench

//  Upstream feeder for the SquareRoot stage in the ray/sphere intersection path.

---
 rtl/discriminant_sqrt_feeder.sv | 248 ++++++++++++++++++++++++
 tb/tb_discriminant_sqrt_feeder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/discriminant_sqrt_feeder.sv
// Discriminant feeder: D = b*b - c by shift-add, converted to unsigned 8.4 and
// handed to the SquareRoot stage; miss/hit/root returned on a valid/ready port.
module discriminant_sqrt_feeder #(
   parameter int B_W     = 12,
   parameter int C_W     = 24,
   parameter int A_W     = 12,
   parameter int SQRT_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [B_W-1:0]    in_b,
   input  logic [C_W-1:0]    in_c,
   output logic              sqrt_start,
   output logic [A_W-1:0]    sqrt_A,
   input  logic              sqrt_busy,
   input  logic [SQRT_W-1:0] sqrt_Q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_hit,
   output logic [SQRT_W-1:0] out_sqrt,
   output logic              out_err
);

   localparam int D_W   = C_W + 1;
   localparam int CNT_W = $clog2(B_W);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MULT   = 3'd1,
      ST_SUB    = 3'd2,
      ST_LAUNCH = 3'd3,
      ST_WAIT   = 3'd4,
      ST_RESULT = 3'd5
   } state_t;

   // Magnitude of a two's complement b; the most negative code maps to 2^(B_W-1).
   function automatic logic [B_W-1:0] abs_b(input logic [B_W-1:0] v);
      if (v[B_W-1]) begin
         return ~v + {{(B_W-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   // Clamp the non-negative 8.4 magnitude to the SquareRoot operand range.
   function automatic logic [A_W-1:0] sat_fix(input logic [C_W-1:0] mag);
      if (|mag[C_W-1:A_W]) begin
         return {A_W{1'b1}};
      end else begin
         return mag[A_W-1:0];
      end
   endfunction

   state_t              state_r, state_s;
   logic [B_W-1:0]      b_abs_r, b_abs_s;
   logic [C_W-1:0]      mcand_r, mcand_s;
   logic [C_W-1:0]      c_r, c_s;
   logic [C_W-1:0]      acc_r, acc_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [TMR_W-1:0]    timer_r, timer_s;
   logic                in_ready_r, in_ready_s;
   logic                sqrt_start_r, sqrt_start_s;
   logic [A_W-1:0]      sqrt_a_r, sqrt_a_s;
   logic                out_valid_r, out_valid_s;
   logic                out_hit_r, out_hit_s;
   logic [SQRT_W-1:0]   out_sqrt_r, out_sqrt_s;
   logic                out_err_r, out_err_s;
   logic [D_W-1:0]      d_s;
   logic [D_W-1:0]      d_shr_s;
   logic [A_W-1:0]      d_fix_s;

   // State register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and next-register values.
   always_comb begin
      state_s      = state_r;
      b_abs_s      = b_abs_r;
      mcand_s      = mcand_r;
      c_s          = c_r;
      acc_s        = acc_r;
      cnt_s        = cnt_r;
      timer_s      = timer_r;
      sqrt_start_s = sqrt_start_r;
      sqrt_a_s     = sqrt_a_r;
      out_valid_s  = out_valid_r;
      out_hit_s    = out_hit_r;
      out_sqrt_s   = out_sqrt_r;
      out_err_s    = out_err_r;
      d_s          = {1'b0, acc_r} - {c_r[C_W-1], c_r};
      d_shr_s      = $signed(d_s) >>> 3'd4;
      d_fix_s      = sat_fix(d_shr_s[C_W-1:0]);

      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               b_abs_s = abs_b(in_b);
               mcand_s = C_W'(abs_b(in_b));
               c_s     = in_c;
               acc_s   = '0;
               cnt_s   = '0;
               state_s = ST_MULT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MULT: begin
            // Multiplier shifts right, multiplicand left: one partial product per cycle.
            if (b_abs_r[0]) begin
               acc_s = acc_r + mcand_r;
            end else begin
               acc_s = acc_r;
            end
            b_abs_s = b_abs_r >> 1;
            mcand_s = mcand_r << 1;
            cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_W'(B_W - 1)) begin
               state_s = ST_SUB;
            end else begin
               state_s = ST_MULT;
            end
         end
         ST_SUB: begin
            out_sqrt_s = '0;
            out_err_s  = 1'b0;
            if (d_shr_s[D_W-1]) begin
               out_hit_s   = 1'b0;
               out_valid_s = 1'b1;
               state_s     = ST_RESULT;
            end else begin
               out_hit_s = 1'b1;
               // SquareRoot cannot normalise a zero operand, so answer directly.
               if (d_fix_s == '0) begin
                  out_valid_s = 1'b1;
                  state_s     = ST_RESULT;
               end else begin
                  sqrt_a_s     = d_fix_s;
                  sqrt_start_s = 1'b1;
                  timer_s      = '0;
                  state_s      = ST_LAUNCH;
               end
            end
         end
         ST_LAUNCH: begin
            if (sqrt_busy) begin
               sqrt_start_s = 1'b0;
               timer_s      = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
               state_s      = ST_WAIT;
            end else if (timer_r == TMR_W'(TIMEOUT)) begin
               sqrt_start_s = 1'b0;
               out_err_s    = 1'b1;
               out_hit_s    = 1'b0;
               out_sqrt_s   = '0;
               out_valid_s  = 1'b1;
               state_s      = ST_RESULT;
            end else begin
               timer_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
               state_s = ST_LAUNCH;
            end
         end
         ST_WAIT: begin
            // The root is only valid in the cycle busy falls.
            if (!sqrt_busy) begin
               out_sqrt_s  = sqrt_Q;
               out_valid_s = 1'b1;
               state_s     = ST_RESULT;
            end else if (timer_r == TMR_W'(TIMEOUT)) begin
               out_err_s   = 1'b1;
               out_hit_s   = 1'b0;
               out_sqrt_s  = '0;
               out_valid_s = 1'b1;
               state_s     = ST_RESULT;
            end else begin
               timer_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
               state_s = ST_WAIT;
            end
         end
         ST_RESULT: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               out_err_s   = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_RESULT;
            end
         end
         default: begin
            state_s      = ST_IDLE;
            sqrt_start_s = 1'b0;
            out_valid_s  = 1'b0;
         end
      endcase

      in_ready_s = (state_s == ST_IDLE);
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         b_abs_r      <= '0;
         mcand_r      <= '0;
         c_r          <= '0;
         acc_r        <= '0;
         cnt_r        <= '0;
         timer_r      <= '0;
         in_ready_r   <= 1'b1;
         sqrt_start_r <= 1'b0;
         sqrt_a_r     <= '0;
         out_valid_r  <= 1'b0;
         out_hit_r    <= 1'b0;
         out_sqrt_r   <= '0;
         out_err_r    <= 1'b0;
      end else begin
         b_abs_r      <= b_abs_s;
         mcand_r      <= mcand_s;
         c_r          <= c_s;
         acc_r        <= acc_s;
         cnt_r        <= cnt_s;
         timer_r      <= timer_s;
         in_ready_r   <= in_ready_s;
         sqrt_start_r <= sqrt_start_s;
         sqrt_a_r     <= sqrt_a_s;
         out_valid_r  <= out_valid_s;
         out_hit_r    <= out_hit_s;
         out_sqrt_r   <= out_sqrt_s;
         out_err_r    <= out_err_s;
      end
   end

   assign in_ready   = in_ready_r;
   assign sqrt_start = sqrt_start_r;
   assign sqrt_A     = sqrt_a_r;
   assign out_valid  = out_valid_r;
   assign out_hit    = out_hit_r;
   assign out_sqrt   = out_sqrt_r;
   assign out_err    = out_err_r;

endmodule

// File: tb/tb_discriminant_sqrt_feeder.sv
// Scoreboard bench for discriminant_sqrt_feeder with a behavioural SquareRoot
// model and an arithmetic reference for D = b*b - c.
module tb_discriminant_sqrt_feeder;

   localparam int B_W     = 12;
   localparam int C_W     = 24;
   localparam int A_W     = 12;
   localparam int SQRT_W  = 16;
   localparam int TIMEOUT = 255;
   localparam int SQ_LAT  = 1 + 16;

   logic              clk = 1'b0;
   logic              rst_;
   logic              in_valid;
   logic              in_ready;
   logic [B_W-1:0]    in_b;
   logic [C_W-1:0]    in_c;
   logic              sqrt_start;
   logic [A_W-1:0]    sqrt_A;
   logic              sqrt_busy;
   logic [SQRT_W-1:0] sqrt_Q;
   logic              out_valid;
   logic              out_ready;
   logic              out_hit;
   logic [SQRT_W-1:0] out_sqrt;
   logic              out_err;

   typedef struct {
      logic              hit;
      logic [SQRT_W-1:0] sq;
      logic              err;
      logic              launched;
      logic [A_W-1:0]    a;
      int                hs;
      int                lat_min;
      int                lat_max;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   logic hold_ready = 1'b0;
   logic sq_dead    = 1'b0;

   discriminant_sqrt_feeder dut (
      .clk(clk), .rst_(rst_),
      .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b), .in_c(in_c),
      .sqrt_start(sqrt_start), .sqrt_A(sqrt_A), .sqrt_busy(sqrt_busy), .sqrt_Q(sqrt_Q),
      .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
      .out_sqrt(out_sqrt), .out_err(out_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [SQRT_W-1:0] isqrt(input longint n);
      longint r = 0;
      longint t;
      for (int k = SQRT_W - 1; k >= 0; k--) begin
         t = r | (longint'(1) << k);
         if (t * t <= n) r = t;
      end
      return SQRT_W'(r);
   endfunction

   // SquareRoot stand-in: busy one cycle after start, 16 busy cycles, Q only on the fall.
   logic [4:0]        sq_cnt;
   logic [SQRT_W-1:0] sq_res;
   always @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sqrt_busy <= 1'b0;
         sq_cnt    <= 5'd0;
         sq_res    <= '0;
         sqrt_Q    <= '0;
      end else begin
         sqrt_Q <= SQRT_W'($urandom);
         if (sq_cnt != 5'd0) begin
            sq_cnt <= sq_cnt - 5'd1;
            if (sq_cnt == 5'd1) begin
               sqrt_busy <= 1'b0;
               sqrt_Q    <= sq_res;
            end
         end else if (sqrt_start && !sq_dead) begin
            sqrt_busy <= 1'b1;
            sq_cnt    <= 5'd16;
            sq_res    <= isqrt(longint'(sqrt_A) * 4096);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t ref_model(input logic [B_W-1:0] b, input logic [C_W-1:0] c,
                                      input logic dead);
      exp_t   r;
      longint bi = longint'($signed(b));
      longint ci = longint'($signed(c));
      longint d  = bi * bi - ci;
      longint f;
      r.hit = 1'b0; r.sq = '0; r.err = 1'b0; r.launched = 1'b0; r.a = '0; r.hs = 0;
      r.lat_min = B_W + 2; r.lat_max = B_W + 2;
      if (d >= 0) begin
         f = d / 16;
         if (f > 4095) f = 4095;
         r.hit = 1'b1;
         if (f != 0) begin
            r.launched = 1'b1;
            r.a = A_W'(f);
            if (dead) begin
               r.hit = 1'b0; r.err = 1'b1;
               r.lat_min = TIMEOUT; r.lat_max = TIMEOUT + 2 * B_W;
            end else begin
               r.sq = isqrt(f * 4096);
               r.lat_min = B_W + 3 + SQ_LAT; r.lat_max = B_W + 3 + SQ_LAT;
            end
         end
      end
      return r;
   endfunction

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2 out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compares first valid cycle to the scoreboard, then checks stability.
   initial begin
      exp_t              e;
      int                lat;
      logic              prev_v = 1'b0;
      int                starts = 0;
      logic [A_W-1:0]    start_a = '0;
      logic              s_hit = 1'b0, s_err = 1'b0;
      logic [SQRT_W-1:0] s_sqrt = '0;
      forever begin
         @(negedge clk);
         if (!rst_) begin
            prev_v = 1'b0;
            starts = 0;
         end else begin
            if (sqrt_start && starts == 0) start_a = sqrt_A;
            if (sqrt_start) starts++;
            if (out_valid) begin
               chk("in_ready_while_valid", in_ready, 1'b0);
               if (!prev_v) begin
                  if (exp_q.size() == 0) begin
                     checks++; fails++;
                     $display("FAIL unexpected_output: got valid expected none");
                  end else begin
                     e   = exp_q[0];
                     lat = cyc - e.hs + 1;
                     checks++;
                     if (lat < e.lat_min || lat > e.lat_max) begin
                        fails++;
                        $display("FAIL latency: got %0d expected %0d..%0d", lat, e.lat_min, e.lat_max);
                     end
                     chk("out_hit", out_hit, e.hit);
                     chk("out_sqrt", out_sqrt, e.sq);
                     chk("out_err", out_err, e.err);
                     chk("sqrt_launched", starts != 0, e.launched);
                     if (e.launched) begin
                        chk("sqrt_A_at_start", start_a, e.a);
                        chk("sqrt_A_held", sqrt_A, e.a);
                     end
                  end
                  s_hit = out_hit; s_sqrt = out_sqrt; s_err = out_err;
               end else begin
                  chk("hold_hit", out_hit, s_hit);
                  chk("hold_sqrt", out_sqrt, s_sqrt);
                  chk("hold_err", out_err, s_err);
               end
               if (out_ready) begin
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  starts = 0;
                  prev_v = 1'b0;
               end else begin
                  prev_v = 1'b1;
               end
            end else begin
               prev_v = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [B_W-1:0] b, input logic [C_W-1:0] c);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1; in_b = b; in_c = c;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; fails++;
         $display("FAIL in_handshake: got in_ready=0 expected 1 within 2000 cycles");
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         e    = ref_model(b, c, sq_dead);
         e.hs = cyc;
         exp_q.push_back(e);
         repeat (3) begin
            @(negedge clk);
            in_b = B_W'($urandom); in_c = C_W'($urandom);
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      chk({tag, "_sqrt_start"}, sqrt_start, 1'b0);
      chk({tag, "_sqrt_A"}, sqrt_A, 32'd0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_hit"}, out_hit, 1'b0);
      chk({tag, "_out_sqrt"}, out_sqrt, 32'd0);
      chk({tag, "_out_err"}, out_err, 1'b0);
   endtask

   initial begin
      logic [B_W-1:0] rb;
      int             bsq;
      int             ci;
      int             n;
      rst_ = 1'b0; in_valid = 1'b0; in_b = '0; in_c = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_ = 1'b1;

      send(12'h030, 24'h000500); wait_done();
      send(12'h010, 24'h000200); wait_done();
      send(12'h800, 24'h000000); wait_done();
      send(12'h001, 24'h000000); wait_done();

      for (int i = 0; i < 40; i++) begin
         rb  = B_W'($urandom);
         bsq = $signed(rb) * $signed(rb);
         case ($urandom_range(0, 2))
            0:       ci = $signed(C_W'($urandom));
            1:       ci = bsq - int'($urandom_range(0, 70000));
            default: ci = bsq + int'($urandom_range(0, 50));
         endcase
         send(rb, C_W'(ci));
         if (i % 5 == 4) wait_done();
      end
      wait_done();

      sq_dead = 1'b1; hold_ready = 1'b1;
      send(12'h030, 24'h000500);
      n = 0;
      while (!out_valid && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_valid", out_valid, 1'b1);
      repeat (5) @(negedge clk);
      hold_ready = 1'b0;
      wait_done();
      sq_dead = 1'b0;

      send(12'h030, 24'h000500);
      n = 0;
      while (!sqrt_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("busy_before_reset", sqrt_busy, 1'b1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #3 rst_ = 1'b0;
      #1 chk_reset_outputs("midreset");
      exp_q.delete();
      @(posedge clk);
      #3 rst_ = 1'b1;
      send(12'h024, 24'h000100); wait_done();
      send(12'h030, 24'h000500); wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
      $fatal(1, "simulation did not terminate");
   end

endmodule
